// File: rtl/vram_scanout_arbiter_pkg.sv
// Shared constants and FSM encoding for the VRAM scan-out / writer arbiter.
package vram_scanout_arbiter_pkg;
    localparam int H_ACTIVE       = 1024;
    localparam int V_ACTIVE       = 768;
    localparam int BPP            = 4;
    localparam int PPW            = 4;
    localparam int DATA_W         = BPP * PPW;
    localparam int ADDR_W         = 18;
    localparam int HC_W           = 11;
    localparam int VC_W           = 10;
    localparam int WORDS_PER_LINE = H_ACTIVE / PPW;
    localparam int FB_DEPTH       = H_ACTIVE * V_ACTIVE / PPW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;
endpackage

// File: rtl/vram_scanout_arbiter_sync_delay.sv
// N-stage shift register with a selectable reset value, used to align sync/blank with pixels.
module vram_scanout_arbiter_sync_delay #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [N-1:0] r_shift;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_shift <= {N{RST_VAL}};
        else       r_shift <= {r_shift[N-2:0], i_d};
    end

    assign o_q = r_shift[N-1];
endmodule

// File: rtl/vram_scanout_arbiter.sv
// Single-port frame RAM arbiter: scan-out reads every PPW-th active cycle, the clear
// engine or the plotter gets every other cycle; also unpacks words into pixels.
module vram_scanout_arbiter
    import vram_scanout_arbiter_pkg::*;
#(
    parameter int P_WORDS_PER_LINE = WORDS_PER_LINE,
    parameter int P_FB_DEPTH       = FB_DEPTH
) (
    input  logic              i_vga_clock,
    input  logic              i_reset,
    input  logic [HC_W-1:0]   i_hcount,
    input  logic [VC_W-1:0]   i_vcount,
    input  logic              i_hsync_in,
    input  logic              i_vsync_in,
    input  logic              i_at_display_area,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_clear_req,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [BPP-1:0]    o_pixel_out,
    output logic              o_hsync_out,
    output logic              o_vsync_out,
    output logic              o_blank_out
);
    localparam int                LOG_PPW  = $clog2(PPW);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(P_FB_DEPTH - 1);

    arb_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clear_ptr, w_clear_ptr_nxt;
    logic              r_clear_done, w_clear_done_nxt;
    logic              r_load;
    logic [DATA_W-1:0] r_word;
    logic              w_disp_slot;
    logic [ADDR_W-1:0] w_disp_addr;

    assign w_disp_slot = i_at_display_area && (i_hcount[LOG_PPW-1:0] == '0);
    assign w_disp_addr = ADDR_W'(i_vcount) * ADDR_W'(P_WORDS_PER_LINE)
                       + ADDR_W'(i_hcount >> LOG_PPW);

    always_comb begin
        w_state_nxt      = r_state;
        w_clear_ptr_nxt  = r_clear_ptr;
        w_clear_done_nxt = 1'b0;
        o_mem_addr       = '0;
        o_mem_we         = 1'b0;
        o_mem_wdata      = '0;
        o_wr_ack         = 1'b0;

        if (w_disp_slot) begin
            o_mem_addr = w_disp_addr;
        end else if (r_state == ST_CLEAR) begin
            o_mem_we        = 1'b1;
            o_mem_addr      = r_clear_ptr;
            w_clear_ptr_nxt = r_clear_ptr + ADDR_W'(1);
            if (r_clear_ptr == LAST_PTR) begin
                w_state_nxt      = ST_IDLE;
                w_clear_done_nxt = 1'b1;
            end
        end else if (i_wr_req) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
            o_wr_ack    = 1'b1;
        end

        // A clear request only arms the engine; a writer in this same cycle is still served.
        if (r_state == ST_IDLE && i_clear_req) begin
            w_state_nxt     = ST_CLEAR;
            w_clear_ptr_nxt = '0;
        end

        if (i_reset) begin
            o_mem_we = 1'b0;
            o_wr_ack = 1'b0;
        end
    end

    always_ff @(posedge i_vga_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_clear_ptr  <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_ptr  <= w_clear_ptr_nxt;
            r_clear_done <= w_clear_done_nxt;
        end
    end

    // Word arrives one cycle after its read slot; afterwards shift one pixel out per cycle.
    always_ff @(posedge i_vga_clock or posedge i_reset) begin
        if (i_reset) begin
            r_load <= 1'b0;
            r_word <= '0;
        end else begin
            r_load <= w_disp_slot;
            if (r_load) r_word <= i_mem_rdata;
            else        r_word <= r_word >> BPP;
        end
    end

    vram_scanout_arbiter_sync_delay #(.N(2), .RST_VAL(1'b1)) u_hsync_dly (
        .i_clk(i_vga_clock), .i_rst(i_reset), .i_d(i_hsync_in), .o_q(o_hsync_out)
    );
    vram_scanout_arbiter_sync_delay #(.N(2), .RST_VAL(1'b1)) u_vsync_dly (
        .i_clk(i_vga_clock), .i_rst(i_reset), .i_d(i_vsync_in), .o_q(o_vsync_out)
    );
    vram_scanout_arbiter_sync_delay #(.N(2), .RST_VAL(1'b1)) u_blank_dly (
        .i_clk(i_vga_clock), .i_rst(i_reset), .i_d(~i_at_display_area), .o_q(o_blank_out)
    );

    assign o_pixel_out  = o_blank_out ? '0 : r_word[BPP-1:0];
    assign o_clear_busy = (r_state == ST_CLEAR);
    assign o_clear_done = r_clear_done;
endmodule
